mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of wait-state cycles inserted before each acknowledge; legal range 0..15.
REQ-002 Parameter MEM_BYTES, default 256, size of the byte-addressed storage array; fixed power of two.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  initiator request; held high until ack is seen.
REQ-006 wr  input  1  1 = write, 0 = read; valid while req high.
REQ-007 addr  input  32  byte address; valid while req high.
REQ-008 wdata  input  32  big-endian write word; valid while req high and wr high.
REQ-009 ack  output  1  one-cycle completion pulse.
REQ-010 rdata  output  32  big-endian read word; valid only in the ack cycle.
REQ-011 err  output  1  out-of-range flag; valid only in the ack cycle.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and ACK.
- IDLE: req high -> latch wr, addr, wdata; load wait counter with WAIT_CYCLES; go to WAIT, or to ACK when WAIT_CYCLES = 0.
- WAIT: counter decrements each cycle; at counter 1 -> ACK.
- ACK: ack = 1; next state IDLE unconditionally.
REQ-014 Latency SHALL be exactly WAIT_CYCLES+1 cycles from the edge sampling req in IDLE to the edge on which ack is high.
REQ-015 Requests SHALL be sampled only in IDLE; req during WAIT/ACK is ignored; req still high in the IDLE cycle after ACK starts a new transaction (back-to-back throughput of one access per WAIT_CYCLES+2 cycles).
REQ-016 Latched wr/addr/wdata SHALL be used for the whole transaction; changes on inputs after sampling have no effect.
REQ-017 Read: rdata = {mem[a], mem[a+1], mem[a+2], mem[a+3]}, a = addr mod MEM_BYTES, byte indices wrap modulo MEM_BYTES (e.g. a = 255 reads bytes 255, 0, 1, 2).
REQ-018 Write: the same four bytes SHALL be updated with wdata[31:24], [23:16], [15:8], [7:0] on the edge entering ACK; rdata in a write ack cycle = 0.
REQ-019 Unaligned addresses SHALL be legal; no alignment exception.
REQ-020 addr >= MEM_BYTES SHALL produce err = 1 with ack, rdata = 0, no storage modification.
REQ-021 ack, err and rdata SHALL be 0 in every cycle other than the ack cycle.
REQ-022 A read issued immediately after a write to overlapping bytes SHALL return the newly written data.

Reset
REQ-023 Reset SHALL force state IDLE, wait counter 0, ack = 0, err = 0, busy = 0, rdata = 0 immediately, regardless of clock.
REQ-024 Reset SHALL clear all MEM_BYTES storage bytes to 0.
REQ-025 Reset asserted mid-transaction SHALL abort it: no ack, no storage write; after deassertion the block accepts a fresh req in IDLE.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE, WAIT, ACK), the default WAIT_CYCLES and MEM_BYTES constants, and the exception-vector byte addresses 253, 254, 255 used by initiators.
REQ-027 The storage array with its 4-byte big-endian wrap-around read/write port SHALL be one sub-module, mem_byte_array; the FSM, counter and latches live in mem_responder.

Verification
REQ-028 WAIT_CYCLES = 2: write addr 0x10, wdata 0xDEADBEEF, then read 0x10 -> each ack exactly 3 cycles after req sampled, read rdata = 0xDEADBEEF, err = 0.
REQ-029 Wrap: write addr 0xFE, wdata 0x11223344 -> bytes 254 = 0x11, 255 = 0x22, 0 = 0x33, 1 = 0x44; read addr 0x00 -> rdata = 0x3344_0000.
REQ-030 Out of range: read addr 0x100, then write addr 0x1000 with 0xFFFFFFFF -> ack with err = 1, rdata = 0; a subsequent read of 0x00 returns its previous value unchanged.
REQ-031 Reset mid-op: start write addr 0x20, wdata 0xCAFEF00D, assert reset during WAIT -> ack never pulses, busy = 0 at once; read 0x20 afterwards -> 0x00000000.
REQ-032 WAIT_CYCLES = 0 back-to-back: req held high for three reads -> ack every 2nd cycle, busy low only in the intervening IDLE cycles, input changes during ACK not sampled.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the wait-state memory responder: FSM encoding,
// default sizing and the exception-vector byte addresses used by initiators.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam int DEFAULT_WAIT_CYCLES = 2;
    localparam int DEFAULT_MEM_BYTES   = 256;

    localparam logic [31:0] EXC_VEC_0 = 32'd253;
    localparam logic [31:0] EXC_VEC_1 = 32'd254;
    localparam logic [31:0] EXC_VEC_2 = 32'd255;

    function automatic logic addr_in_range(input logic [31:0] addr, input int mem_bytes);
        return addr < 32'(mem_bytes);
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage with a 4-byte big-endian port whose byte indices
// wrap modulo MEM_BYTES; combinational read, write on the clock edge.
module mem_byte_array
    import mem_responder_pkg::*;
#(
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [$clog2(MEM_BYTES)-1:0] addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    mem_q [MEM_BYTES];
    logic [7:0]    mem_d [MEM_BYTES];
    logic [AW-1:0] idx0, idx1, idx2, idx3;

    // Index arithmetic is AW bits wide, so the wrap past the top byte is free.
    assign idx0 = addr;
    assign idx1 = addr + AW'(1);
    assign idx2 = addr + AW'(2);
    assign idx3 = addr + AW'(3);

    assign rdata = {mem_q[idx0], mem_q[idx1], mem_q[idx2], mem_q[idx3]};

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[idx0] = wdata[31:24];
            mem_d[idx1] = wdata[23:16];
            mem_d[idx2] = wdata[15:8];
            mem_d[idx3] = wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: 8'h00};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory slave with programmable wait states: samples a request in IDLE,
// waits WAIT_CYCLES, then pulses ack with read data or an out-of-range error.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int MEM_BYTES   = DEFAULT_MEM_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(MEM_BYTES);

    // Handshake: req/wr/addr/wdata are sampled only on an edge where the FSM is
    // in IDLE and req is high; the initiator holds req until it sees the
    // one-cycle ack, and ack/err/rdata are meaningful only in that ack cycle.

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        cur_wr;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        in_range;
    logic        enter_ack;
    logic        mem_we;
    logic [31:0] mem_rdata;

    // With zero wait states the ACK edge is the sampling edge, so the live
    // inputs stand in for the not-yet-latched copies while in IDLE.
    always_comb begin
        cur_wr    = (state_q == ST_IDLE) ? wr    : wr_q;
        cur_addr  = (state_q == ST_IDLE) ? addr  : addr_q;
        cur_wdata = (state_q == ST_IDLE) ? wdata : wdata_q;
        in_range  = addr_in_range(cur_addr, MEM_BYTES);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        enter_ack = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d   = ST_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d   = ST_ACK;
                    cnt_d     = 4'd0;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign mem_we = enter_ack && cur_wr && in_range;

    always_comb begin
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'h0;
        if (enter_ack) begin
            ack_d   = 1'b1;
            err_d   = !in_range;
            rdata_d = (in_range && !cur_wr) ? mem_rdata : 32'h0;
        end
    end

    mem_byte_array #(
        .MEM_BYTES(MEM_BYTES)
    ) u_mem (
        .clk   (clk),
        .rst   (reset),
        .we    (mem_we),
        .addr  (cur_addr[AW-1:0]),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states and one with none,
// checked against a byte-array reference model through per-instance queues.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int W_A = 2;
  localparam int W_B = 0;
  localparam int EW  = 65;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        busy  [2];
  logic [1:0]  dbg   [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ack_cnt [2];
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [7:0] model_mem [2][256];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  mem_responder #(.WAIT_CYCLES(W_A), .MEM_BYTES(256)) dut_a (
    .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0]),
    .busy(busy[0]), .dbg_state(dbg[0])
  );

  mem_responder #(.WAIT_CYCLES(W_B), .MEM_BYTES(256)) dut_b (
    .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1]),
    .busy(busy[1]), .dbg_state(dbg[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_read(input int d, input int a);
    return {model_mem[d][a % 256], model_mem[d][(a + 1) % 256],
            model_mem[d][(a + 2) % 256], model_mem[d][(a + 3) % 256]};
  endfunction

  task automatic model_txn(input int d, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, output logic e, output logic [31:0] rd);
    int ai;
    ai = int'(a[7:0]);
    e  = (a >= 32'd256);
    rd = 32'h0;
    if (!e) begin
      if (w) begin
        for (int k = 0; k < 4; k++) model_mem[d][(ai + k) % 256] = wd[31 - 8*k -: 8];
      end else begin
        rd = model_read(d, ai);
      end
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) model_mem[d][i] = 8'h00;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic monitor_step(input int d);
    logic [EW-1:0] e;
    if (ack[d]) begin
      if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
        check($sformatf("unexpected_ack%0d", d), 64'(ack[d]), 64'd0);
      end else begin
        if (d == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        check($sformatf("ack_cycle%0d", d), 64'(cyc), 64'(e[64:33]));
        check($sformatf("err%0d", d), 64'(err[d]), 64'(e[32]));
        check($sformatf("rdata%0d", d), 64'(rdata[d]), 64'(e[31:0]));
      end
      ack_cnt[d]++;
    end else begin
      check($sformatf("idle_err%0d", d), 64'(err[d]), 64'd0);
      check($sformatf("idle_rdata%0d", d), 64'(rdata[d]), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    monitor_step(0);
    monitor_step(1);
  end

  // ---------------- drivers ----------------
  task automatic wait_ack(input int d, input int start);
    int waited;
    waited = 0;
    while (ack_cnt[d] == start && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    if (ack_cnt[d] == start) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout%0d: got no ack expected ack within 50 cycles", d);
    end
  endtask

  task automatic do_txn_a(input logic w, input logic [31:0] a, input logic [31:0] wd);
    logic e;
    logic [31:0] rd;
    int start;
    @(negedge clk); #1;
    model_txn(0, w, a, wd, e, rd);
    exp_q0.push_back({32'(cyc + 1 + W_A), e, rd});
    start    = ack_cnt[0];
    req[0]   = 1'b1;
    wr[0]    = w;
    addr[0]  = a;
    wdata[0] = wd;
    @(negedge clk); #1;
    wr[0]    = 1'($urandom_range(0, 1));
    addr[0]  = $urandom;
    wdata[0] = $urandom;
    wait_ack(0, start);
    req[0] = 1'b0;
  endtask

  task automatic b2b_txn_b(input int n, input logic ws[8], input logic [31:0] as[8],
                           input logic [31:0] wds[8]);
    logic e;
    logic [31:0] rd;
    @(negedge clk); #1;
    for (int k = 0; k < n; k++) begin
      model_txn(1, ws[k], as[k], wds[k], e, rd);
      exp_q1.push_back({32'(cyc + 1 + W_B), e, rd});
      req[1]   = 1'b1;
      wr[1]    = ws[k];
      addr[1]  = as[k];
      wdata[1] = wds[k];
      @(negedge clk); #1;
      check("b2b_busy_ack", 64'(busy[1]), 64'd1);
      if (k == n - 1) begin
        req[1] = 1'b0;
      end else begin
        wr[1]    = 1'b1;
        addr[1]  = {24'h0, 8'($urandom)};
        wdata[1] = $urandom;
      end
      @(negedge clk); #1;
      check("b2b_busy_idle", 64'(busy[1]), 64'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        ws  [8];
    logic [31:0] as  [8];
    logic [31:0] wds [8];
    int start;

    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; ack_cnt[d] = 0;
    end
    model_clear();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ack", 64'(ack[d]), 64'd0);
      check("rst_err", 64'(err[d]), 64'd0);
      check("rst_rdata", 64'(rdata[d]), 64'd0);
      check("rst_busy", 64'(busy[d]), 64'd0);
    end
    reset = 1'b0;

    // basic write/read and latency
    do_txn_a(1'b1, 32'h10, 32'hDEADBEEF);
    do_txn_a(1'b0, 32'h10, 32'h0);
    // wrap-around across the top of the array
    do_txn_a(1'b1, 32'hFE, 32'h11223344);
    do_txn_a(1'b0, 32'h00, 32'h0);
    do_txn_a(1'b0, 32'hFE, 32'h0);
    do_txn_a(1'b0, EXC_VEC_2, 32'h0);
    // out of range
    do_txn_a(1'b0, 32'h100, 32'h0);
    do_txn_a(1'b1, 32'h1000, 32'hFFFFFFFF);
    do_txn_a(1'b0, 32'h00, 32'h0);

    // reset in the middle of a write
    @(negedge clk); #1;
    start    = ack_cnt[0];
    req[0]   = 1'b1;
    wr[0]    = 1'b1;
    addr[0]  = 32'h20;
    wdata[0] = 32'hCAFEF00D;
    @(negedge clk); #1;
    check("busy_in_wait", 64'(busy[0]), 64'd1);
    reset = 1'b1;
    model_clear();
    #1;
    check("abort_busy", 64'(busy[0]), 64'd0);
    check("abort_ack", 64'(ack[0]), 64'd0);
    check("abort_state", 64'(dbg[0]), 64'(ST_IDLE));
    req[0] = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("abort_no_ack", 64'(ack_cnt[0]), 64'(start));
    do_txn_a(1'b0, 32'h20, 32'h0);
    do_txn_a(1'b0, 32'h10, 32'h0);

    // random traffic, mostly in range with some far addresses
    for (int i = 0; i < 60; i++) begin
      do_txn_a(1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 263)),
               $urandom);
    end

    // zero-wait back-to-back on the second instance
    ws[0] = 1'b1; as[0] = 32'h04; wds[0] = 32'hA1B2C3D4;
    ws[1] = 1'b0; as[1] = 32'h04; wds[1] = 32'h0;
    ws[2] = 1'b0; as[2] = 32'h05; wds[2] = 32'h0;
    ws[3] = 1'b0; as[3] = 32'h03; wds[3] = 32'h0;
    b2b_txn_b(4, ws, as, wds);
    for (int k = 0; k < 8; k++) begin
      ws[k]  = 1'($urandom_range(0, 1));
      as[k]  = 32'($urandom_range(0, 270));
      wds[k] = $urandom;
    end
    b2b_txn_b(8, ws, as, wds);

    repeat (4) @(negedge clk);
    #1;
    check("q0_drained", 64'(exp_q0.size()), 64'd0);
    check("q1_drained", 64'(exp_q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
